// File: rtl/hanoi_pkg.sv
// Shared types for the Hanoi interpreter sequencer: tokens, error codes, FSM states.
package hanoi_pkg;

  typedef enum logic [2:0] {
    TOK_LEFT       = 3'd0,
    TOK_RIGHT      = 3'd1,
    TOK_TOGGLE     = 3'd2,
    TOK_LOOP_BEGIN = 3'd3,
    TOK_LOOP_END   = 3'd4,
    TOK_NOP        = 3'd5
  } token_t;

  typedef enum logic [1:0] {
    ERR_BAD_TOK    = 2'd0,
    ERR_UNBALANCED = 2'd1,
    ERR_OVERFLOW   = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } hanoi_err_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } hanoi_seq_state_t;

  localparam logic [2:0] TOK_FIRST_BAD = 3'd6;

  // Address width for a memory of n entries, never narrower than one bit.
  function automatic int pc_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hanoi_bracket_stack.sv
// LIFO of open-bracket positions used while a program streams in.
module hanoi_bracket_stack
  import hanoi_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  W     = 4,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic          empty,
  output logic          full,
  output logic [DW-1:0] depth
);

  logic [W-1:0]  entry_r [DEPTH];
  logic [DW-1:0] depth_r;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] top_idx_s;

  assign wr_idx_s  = AW'(depth_r);
  assign top_idx_s = AW'(depth_r - DW'(1));
  assign empty     = (depth_r == DW'(0));
  assign full      = (depth_r == DW'(DEPTH));
  assign depth     = depth_r;

  // Top-of-stack read, zero when nothing is open.
  always_comb begin
    if (empty) begin
      top = '0;
    end else begin
      top = entry_r[top_idx_s];
    end
  end

  // Occupancy count; push takes priority if both are requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_r <= DW'(0);
    end else if (clr) begin
      depth_r <= DW'(0);
    end else if (push && !full) begin
      depth_r <= depth_r + DW'(1);
    end else if (pop && !empty) begin
      depth_r <= depth_r - DW'(1);
    end else begin
      depth_r <= depth_r;
    end
  end

  // Entry storage needs no reset: only slots below depth are ever read.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      entry_r[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/hanoi_seq_ctrl.sv
// Load/check/run sequencer for the Hanoi core. Optional run-cycle budget is
// compiled in with HANOI_STEP_LIMIT_EN.
module hanoi_seq_ctrl
  import hanoi_pkg::*;
#(
  parameter int  PROG_SIZE = 8,
  parameter int  MAX_STEPS = 256,
  localparam int MEM_SIZE  = PROG_SIZE + 1,
  localparam int PC_BITS   = pc_bits(MEM_SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic [2:0]         tok_data,
  input  logic               tok_last,
  output logic               core_run,
  input  logic [PC_BITS-1:0] core_pc,
  output logic [2:0]         core_tok,
  output logic [PC_BITS-1:0] core_jmp,
  input  logic               core_halt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  hanoi_seq_state_t   state_r;
  hanoi_seq_state_t   state_nx_s;
  logic [PC_BITS-1:0] wr_ptr_r;
  logic [PC_BITS-1:0] wr_ptr_inc_s;
  logic [2:0]         mem_r [MEM_SIZE];
  logic [PC_BITS-1:0] jmp_r [MEM_SIZE];

  logic               hs_s;
  logic               is_begin_s;
  logic               is_end_s;
  logic               load_clr_s;
  logic               mem_wr_s;
  logic               trap_wr_s;
  logic               push_s;
  logic               pop_s;
  logic               unbal_last_s;
  logic               step_hit_s;
  logic [1:0]         err_code_nx_s;

  logic [PC_BITS-1:0] stk_top_s;
  logic [PC_BITS-1:0] stk_top_inc_s;
  logic [PC_BITS-1:0] stk_depth_s;
  logic               stk_empty_s;
  logic               stk_full_s;

  assign hs_s          = tok_valid & tok_ready;
  assign is_begin_s    = (tok_data == TOK_LOOP_BEGIN);
  assign is_end_s      = (tok_data == TOK_LOOP_END);
  assign wr_ptr_inc_s  = wr_ptr_r + PC_BITS'(1);
  assign stk_top_inc_s = stk_top_s + PC_BITS'(1);

  hanoi_bracket_stack #(
    .DEPTH (PROG_SIZE),
    .W     (PC_BITS)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (load_clr_s),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (wr_ptr_r),
    .top       (stk_top_s),
    .empty     (stk_empty_s),
    .full      (stk_full_s),
    .depth     (stk_depth_s)
  );

  // Open-bracket count left over once the current token is applied.
  always_comb begin
    if (is_begin_s) begin
      unbal_last_s = 1'b1;
    end else if (is_end_s) begin
      unbal_last_s = (stk_depth_s != PC_BITS'(1));
    end else begin
      unbal_last_s = (stk_depth_s != PC_BITS'(0));
    end
  end

`ifdef HANOI_STEP_LIMIT_EN
  localparam int STEP_BITS = $clog2(MAX_STEPS + 1);
  logic [STEP_BITS-1:0] step_cnt_r;

  // Run-cycle counter, restarted each time RUN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_r <= STEP_BITS'(0);
    end else if ((state_nx_s == ST_RUN) && (state_r != ST_RUN)) begin
      step_cnt_r <= STEP_BITS'(0);
    end else if (core_run) begin
      step_cnt_r <= step_cnt_r + STEP_BITS'(1);
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  assign step_hit_s = core_run && (step_cnt_r == STEP_BITS'(MAX_STEPS - 1));
`else
  // No budget in this build; the term is constant false.
  assign step_hit_s = (MAX_STEPS < 0);
`endif

  // Next-state, load checks (priority BAD_TOK > OVERFLOW > UNBALANCED), write strobes.
  always_comb begin
    state_nx_s    = state_r;
    err_code_nx_s = err_code;
    load_clr_s    = 1'b0;
    mem_wr_s      = 1'b0;
    trap_wr_s     = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nx_s    = ST_LOAD;
          load_clr_s    = 1'b1;
          err_code_nx_s = 2'd0;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_LOAD: begin
        if (!hs_s) begin
          state_nx_s = ST_LOAD;
        end else if (tok_data >= TOK_FIRST_BAD) begin
          state_nx_s    = ST_ERR;
          err_code_nx_s = ERR_BAD_TOK;
        end else if (wr_ptr_r == PC_BITS'(PROG_SIZE)) begin
          state_nx_s    = ST_ERR;
          err_code_nx_s = ERR_OVERFLOW;
        end else if (is_end_s && stk_empty_s) begin
          state_nx_s    = ST_ERR;
          err_code_nx_s = ERR_UNBALANCED;
        end else begin
          mem_wr_s = 1'b1;
          push_s   = is_begin_s & ~stk_full_s;
          pop_s    = is_end_s;
          if (!tok_last) begin
            state_nx_s = ST_LOAD;
          end else if (unbal_last_s) begin
            state_nx_s    = ST_ERR;
            err_code_nx_s = ERR_UNBALANCED;
          end else begin
            trap_wr_s  = 1'b1;
            state_nx_s = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (core_halt) begin
          state_nx_s = ST_DONE;
        end else if (step_hit_s) begin
          state_nx_s    = ST_ERR;
          err_code_nx_s = ERR_TIMEOUT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, write pointer and status outputs, all registered off next-state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      tok_ready <= 1'b0;
      core_run  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      wr_ptr_r  <= PC_BITS'(0);
    end else begin
      state_r   <= state_nx_s;
      tok_ready <= (state_nx_s == ST_LOAD);
      core_run  <= (state_nx_s == ST_RUN);
      busy      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_RUN);
      done      <= (state_nx_s == ST_DONE);
      err       <= (state_nx_s == ST_ERR);
      err_code  <= err_code_nx_s;
      if (load_clr_s) begin
        wr_ptr_r <= PC_BITS'(0);
      end else if (mem_wr_s) begin
        wr_ptr_r <= wr_ptr_inc_s;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
    end
  end

  // Program memory; the slot after the last token becomes the NOP trap.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[wr_ptr_r] <= tok_data;
    end
    if (trap_wr_s) begin
      mem_r[wr_ptr_inc_s] <= TOK_NOP;
    end
  end

  // Jump table is wiped at load start so non-bracket entries read zero.
  always_ff @(posedge clk) begin
    if (load_clr_s) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        jmp_r[i] <= PC_BITS'(0);
      end
    end else if (pop_s) begin
      jmp_r[stk_top_s] <= wr_ptr_inc_s;
      jmp_r[wr_ptr_r]  <= stk_top_inc_s;
    end
  end

  // Zero-latency fetch port; out-of-range addresses see a NOP.
  always_comb begin
    if ({1'b0, core_pc} < (PC_BITS + 1)'(MEM_SIZE)) begin
      core_tok = mem_r[core_pc];
      core_jmp = jmp_r[core_pc];
    end else begin
      core_tok = TOK_NOP;
      core_jmp = PC_BITS'(0);
    end
  end

endmodule

// File: tb/tb_hanoi_seq_ctrl.sv
// Directed plus randomized bench for hanoi_seq_ctrl against a queue-based program model.
module tb_hanoi_seq_ctrl;

  localparam int PROG_SIZE = 8;
  localparam int MAX_STEPS = 4;
  localparam int MEM_SIZE  = PROG_SIZE + 1;

  logic       clk = 1'b0;
  logic       rst_n, start, tok_valid, tok_last, core_halt;
  logic [2:0] tok_data;
  logic [3:0] core_pc;
  logic       tok_ready, core_run, busy, done, err;
  logic [2:0] core_tok;
  logic [3:0] core_jmp;
  logic [1:0] err_code;

  int prog[$];
  int exp_mem[16];
  int exp_jmp[16];
  bit exp_br[16];
  bit exp_ok;
  int exp_code, exp_n, exp_wr;
  int n_pass   = 0;
  int n_checks = 0;

  hanoi_seq_ctrl #(.PROG_SIZE(PROG_SIZE), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_data(tok_data), .tok_last(tok_last), .core_run(core_run), .core_pc(core_pc),
    .core_tok(core_tok), .core_jmp(core_jmp), .core_halt(core_halt), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: walk the token list applying the load rules directly.
  task automatic model_prog();
    int stk[$];
    int cnt;
    cnt      = 0;
    exp_ok   = 1'b0;
    exp_code = 0;
    exp_n    = prog.size();
    exp_wr   = 0;
    for (int i = 0; i < 16; i++) begin
      exp_jmp[i] = 0;
      exp_br[i]  = 1'b0;
    end
    for (int i = 0; i < prog.size(); i++) begin
      int t;
      t = prog[i];
      exp_n  = i + 1;
      exp_wr = cnt;
      if (t >= 6) begin exp_code = 0; return; end
      if (cnt == PROG_SIZE) begin exp_code = 2; return; end
      if (t == 4 && stk.size() == 0) begin exp_code = 1; return; end
      exp_mem[cnt] = t;
      if (t == 3) stk.push_back(cnt);
      else if (t == 4) begin
        int b;
        b = stk.pop_back();
        exp_jmp[b] = cnt + 1;
        exp_jmp[cnt] = b + 1;
        exp_br[b] = 1'b1;
        exp_br[cnt] = 1'b1;
      end
      cnt++;
      exp_wr = cnt;
      if (i == prog.size() - 1) begin
        if (stk.size() != 0) begin exp_code = 1; return; end
        exp_mem[cnt] = 5;
        exp_ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic gen_prog();
    int len, open, rem;
    prog.delete();
    if ($urandom_range(0, 3) == 0) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        prog.push_back(($urandom_range(0, 15) < 14) ? $urandom_range(0, 5) : $urandom_range(6, 7));
    end else begin
      len  = $urandom_range(1, PROG_SIZE);
      open = 0;
      for (int i = 0; i < len; i++) begin
        rem = len - i;
        if (open > 0 && (rem == open || $urandom_range(0, 2) == 0)) begin
          prog.push_back(4); open--;
        end else if (rem > open + 1 && $urandom_range(0, 3) == 0) begin
          prog.push_back(3); open++;
        end else begin
          prog.push_back(($urandom_range(0, 4) == 0) ? 5 : $urandom_range(0, 2));
        end
      end
    end
  endtask

  // Start, stream prog with random idle gaps, then check outcome and memory image.
  task automatic do_load();
    int gap, top_pc;
    model_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("load_ready", tok_ready, 1);
    check("load_busy", busy, 1);
    check("load_done_clr", done, 0);
    check("load_err_clr", err, 0);
    check("load_code_clr", err_code, 0);
    for (int i = 0; i < exp_n; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if (gap > 0) begin
        tok_valid = 1'b0;
        repeat (gap) @(negedge clk);
        check("gap_ready", tok_ready, 1);
      end
      tok_valid = 1'b1;
      tok_data  = 3'(prog[i]);
      tok_last  = (i == prog.size() - 1);
      @(negedge clk);
    end
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    check("post_ready", tok_ready, 0);
    if (exp_ok) begin
      check("ok_run", core_run, 1);
      check("ok_busy", busy, 1);
      check("ok_err", err, 0);
    end else begin
      check("err_flag", err, 1);
      check("err_code", err_code, exp_code);
      check("err_run", core_run, 0);
      check("err_busy", busy, 0);
    end
    top_pc = exp_ok ? exp_wr : exp_wr - 1;
    for (int p = 0; p <= top_pc; p++) begin
      core_pc = 4'(p);
      #1;
      check("mem_tok", core_tok, exp_mem[p]);
      if (exp_ok && exp_br[p]) check("jmp_tab", core_jmp, exp_jmp[p]);
    end
    if (exp_ok) begin
      for (int p = MEM_SIZE; p < 16; p++) begin
        core_pc = 4'(p);
        #1;
        check("oob_nop", core_tok, 5);
      end
    end
    core_pc = 4'd0;
  endtask

  // Called in run cycle 1; core_halt is raised during run cycle k.
  task automatic run_halt(input int k);
    for (int j = 1; j < k; j++) begin
      @(negedge clk);
      check("run_hold", core_run, 1);
    end
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_run", core_run, 0);
    check("halt_err", err, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tok_valid = 1'b0; tok_last = 1'b0;
    core_halt = 1'b0; tok_data = 3'd0; core_pc = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", tok_ready, 0);
    check("rst_run", core_run, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic loop program, start ignored while running
    prog = {3, 1, 4};
    do_load();
    core_pc = 4'd0; #1; check("t1_jmp0", core_jmp, 3);
    core_pc = 4'd2; #1; check("t1_jmp2", core_jmp, 1);
    core_pc = 4'd3; #1; check("t1_trap", core_tok, 5);
    core_pc = 4'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_ign_run", core_run, 1);
    check("start_ign_ready", tok_ready, 0);
    run_halt(1);

    // Error cases and priorities
    prog = {4};          do_load();
    prog = {3, 3, 4};    do_load();
    prog = {7};          do_load();
    prog = {0, 7};       do_load();
    prog.delete(); repeat (9) prog.push_back(0); do_load();
    check("ovf_code", err_code, 2);
    prog.delete(); repeat (8) prog.push_back(0); prog.push_back(7); do_load();
    prog.delete(); repeat (8) prog.push_back(1); prog.push_back(4); do_load();
    prog = {3, 0, 0, 0, 0, 0, 0, 4}; do_load();
    run_halt(2);

    // Halt on a later run cycle, done sticky
    prog = {0, 1, 2}; do_load();
`ifdef HANOI_STEP_LIMIT_EN
    run_halt(4);
`else
    run_halt(5);
`endif
    repeat (3) @(negedge clk);
    check("done_sticky", done, 1);

    for (int r = 0; r < 30; r++) begin
      gen_prog();
      do_load();
`ifdef HANOI_STEP_LIMIT_EN
      if (exp_ok) run_halt($urandom_range(1, MAX_STEPS));
`else
      if (exp_ok) run_halt($urandom_range(1, 12));
`endif
    end

    // Run without halt
    prog = {2, 2}; do_load();
`ifdef HANOI_STEP_LIMIT_EN
    for (int j = 1; j < MAX_STEPS; j++) begin
      @(negedge clk);
      check("to_run", core_run, 1);
    end
    @(negedge clk);
    check("to_err", err, 1);
    check("to_code", err_code, 3);
    check("to_run_off", core_run, 0);
`else
    repeat (20) begin
      @(negedge clk);
      check("long_run", core_run, 1);
      check("long_err", err, 0);
    end
    run_halt(1);
`endif

    // Asynchronous reset mid-RUN
    prog = {0, 3, 1, 4}; do_load();
    #2 rst_n = 1'b0;
    #1;
    check("arst_run", core_run, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", tok_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", busy, 0);

    // Asynchronous reset mid-LOAD
    start = 1'b1; @(negedge clk); start = 1'b0;
    tok_valid = 1'b1; tok_data = 3'd0; @(negedge clk); tok_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("lrst_ready", tok_ready, 0);
    check("lrst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;

    prog = {1, 0}; do_load();
    run_halt(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
